vx_pe_gather: RTL and testbench

Result-side lane gatherer for serialized FPU processing elements. It accepts one beat per cycle from NUM_PES PE result ports, places each beat at its lane group, and emits one full NUM_LANES-wide result with its tag once every group has arrived. It sits between a shared PE pipeline (FDIV, FSQRT) and the FPU response arbiter. It is the gathering counterpart of the lane-to-PE scatter stage that feeds those PEs.

---
 rtl/vx_pe_gather.sv | 157 +++++++++++++++
 tb/tb_vx_pe_gather.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/vx_pe_gather.sv
// Gathers NUM_PES-wide PE result beats into one NUM_LANES-wide tagged result.
// Define PE_GATHER_DBUF_EN to add a separate assembly buffer in front of the output register.
module vx_pe_gather #(
  parameter int NUM_LANES = 4,
  parameter int NUM_PES   = 1,
  parameter int DATAW     = 37,
  parameter int TAG_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [NUM_PES*DATAW-1:0]      data_in,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [NUM_LANES*DATAW-1:0]    data_out,
  output logic [TAG_WIDTH-1:0]          tag_out
);

  localparam int BATCHES = NUM_LANES / NUM_PES;
  localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BATCHES - 1);

  logic [BW-1:0]              beat_q, beat_d;
  logic                       valid_q, valid_d;
  logic [NUM_LANES*DATAW-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]       tag_q, tag_d;

  logic                       fire_s, last_s;
  logic [NUM_LANES*DATAW-1:0] base_data_s, merged_data_s;
  logic [TAG_WIDTH-1:0]       base_tag_s, merged_tag_s;

  assign fire_s = valid_in & ready_in;
  assign last_s = (beat_q == LAST_BEAT);

  // Lane image of the batch being assembled, including the beat accepted this cycle
  always_comb begin
    merged_data_s = base_data_s;
    merged_tag_s  = base_tag_s;
    if (fire_s) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (beat_q == BW'(l / NUM_PES)) begin
          merged_data_s[l*DATAW +: DATAW] = data_in[(l % NUM_PES)*DATAW +: DATAW];
        end else begin
          merged_data_s[l*DATAW +: DATAW] = base_data_s[l*DATAW +: DATAW];
        end
      end
      if (beat_q == {BW{1'b0}}) begin
        merged_tag_s = tag_in;
      end else begin
        merged_tag_s = base_tag_s;
      end
    end else begin
      merged_data_s = base_data_s;
    end
  end

  // Beat counter wraps after the final beat of a batch
  always_comb begin
    beat_d = beat_q;
    if (fire_s) begin
      beat_d = last_s ? {BW{1'b0}} : beat_q + BW'(1);
    end else begin
      beat_d = beat_q;
    end
  end

`ifdef PE_GATHER_DBUF_EN
  logic                       asm_full_q, asm_full_d;
  logic [NUM_LANES*DATAW-1:0] asm_q, asm_d;
  logic [TAG_WIDTH-1:0]       asm_tag_q, asm_tag_d;
  logic                       move_s;

  assign base_data_s = asm_q;
  assign base_tag_s  = asm_tag_q;
  assign move_s      = ~valid_q | ready_out;
  assign ready_in    = reset & ~asm_full_q;

  // A completed batch bypasses assembly when the output slot is free, otherwise parks there
  always_comb begin
    asm_d      = merged_data_s;
    asm_tag_d  = merged_tag_s;
    asm_full_d = asm_full_q;
    data_d     = data_q;
    tag_d      = tag_q;
    valid_d    = valid_q & ~ready_out;
    if (asm_full_q && move_s) begin
      data_d     = asm_q;
      tag_d      = asm_tag_q;
      valid_d    = 1'b1;
      asm_full_d = 1'b0;
    end else if (fire_s && last_s) begin
      if (move_s) begin
        data_d  = merged_data_s;
        tag_d   = merged_tag_s;
        valid_d = 1'b1;
      end else begin
        asm_full_d = 1'b1;
      end
    end else begin
      asm_full_d = asm_full_q;
    end
  end

  // Assembly buffer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q      <= '0;
      asm_tag_q  <= '0;
      asm_full_q <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      asm_tag_q  <= asm_tag_d;
      asm_full_q <= asm_full_d;
    end
  end
`else
  assign base_data_s = data_q;
  assign base_tag_s  = tag_q;
  assign ready_in    = reset & (~valid_q | ready_out);

  // Single register set: assembly writes straight into the output image
  always_comb begin
    data_d  = merged_data_s;
    tag_d   = merged_tag_s;
    valid_d = valid_q;
    if (fire_s && last_s) begin
      valid_d = 1'b1;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end
`endif

  // Output register and beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_vx_pe_gather.sv
// Randomized bench for vx_pe_gather with NUM_PES = 1, 2 and 4 side by side,
// checked against a queue-level model of completed batches.
module tb_vx_pe_gather;

  localparam int NL = 4;
  localparam int DW = 37;
  localparam int TW = 4;
  localparam int RW = NL*DW + TW;
`ifdef PE_GATHER_DBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk;
  logic reset;
  logic [2:0] vi, ri, vo, ro;
  logic [2:0][NL*DW-1:0] din, dout;
  logic [2:0][TW-1:0] tin, tout;

  int checks = 0;
  int failures = 0;

  // model state per instance
  int beat [3];
  int rn [3];
  int lane_ctr [3];
  logic [TW-1:0] ctag [3];
  logic [DW-1:0] lanes [3][NL];
  logic [RW-1:0] rq [3][2];

  int n, nb;
  logic exp_ri, exp_vo, acc, pop, done;
  logic [RW-1:0] res;
  logic [63:0] rnd;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NP = 1 << g;
    vx_pe_gather #(.NUM_LANES(NL), .NUM_PES(NP), .DATAW(DW), .TAG_WIDTH(TW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (vi[g]),
      .ready_in  (ri[g]),
      .data_in   (din[g][NP*DW-1:0]),
      .tag_in    (tin[g]),
      .valid_out (vo[g]),
      .ready_out (ro[g]),
      .data_out  (dout[g]),
      .tag_out   (tout[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int g = 0; g < 3; g++) begin
      beat[g] = 0;
      rn[g]   = 0;
      ctag[g] = '0;
      for (int l = 0; l < NL; l++) lanes[g][l] = '0;
    end
  endtask

  initial begin
    reset = 1'b0;
    vi = '0; ro = '0; din = '0; tin = '0;
    for (int g = 0; g < 3; g++) lane_ctr[g] = 10;
    model_clear();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 2) reset = 1'b1;
      if (cyc == 700 || cyc == 1500) begin
        reset = 1'b0;
        model_clear();
      end
      if (cyc == 702 || cyc == 1502) reset = 1'b1;

      for (int g = 0; g < 3; g++) begin
        n = 1 << g;
        if (cyc < 30 || (cyc >= 690 && cyc < 700)) begin
          vi[g] = 1'b1;
          ro[g] = 1'b1;
          tin[g] = 4'd5;
          for (int p = 0; p < n; p++) begin
            din[g][p*DW +: DW] = DW'(lane_ctr[g]);
            lane_ctr[g]++;
          end
        end else begin
          if (cyc < 50) begin
            vi[g] = 1'b1;
            ro[g] = 1'b0;
          end else if (((cyc / 40) % 3) == 0) begin
            vi[g] = ($urandom_range(0, 3) != 0);
            ro[g] = ($urandom_range(0, 4) == 0);
          end else begin
            vi[g] = ($urandom_range(0, 3) != 0);
            ro[g] = ($urandom_range(0, 7) != 0);
          end
          tin[g] = TW'($urandom());
          for (int p = 0; p < n; p++) begin
            rnd = {32'($urandom()), 32'($urandom())};
            din[g][p*DW +: DW] = rnd[DW-1:0];
          end
        end
      end

      #1;
      for (int g = 0; g < 3; g++) begin
        n  = 1 << g;
        nb = NL / n;
        exp_ri = reset && ((CAP == 2) ? (rn[g] < 2) : (rn[g] == 0 || ro[g]));
        exp_vo = (rn[g] > 0);
        check_eq($sformatf("p%0d_ready_in", n), RW'(ri[g]), RW'(exp_ri));
        check_eq($sformatf("p%0d_valid_out", n), RW'(vo[g]), RW'(exp_vo));
        if (exp_vo) check_eq($sformatf("p%0d_result", n), {tout[g], dout[g]}, rq[g][0]);
        if (!reset) check_eq($sformatf("p%0d_reset_out", n), {tout[g], dout[g]}, '0);

        acc  = vi[g] && exp_ri;
        pop  = exp_vo && ro[g];
        done = 1'b0;
        if (acc) begin
          if (beat[g] == 0) ctag[g] = tin[g];
          for (int p = 0; p < n; p++) lanes[g][beat[g]*n + p] = din[g][p*DW +: DW];
          beat[g]++;
          if (beat[g] == nb) begin
            beat[g] = 0;
            done = 1'b1;
            for (int l = 0; l < NL; l++) res[l*DW +: DW] = lanes[g][l];
            res[NL*DW +: TW] = ctag[g];
          end
        end
        if (pop) begin
          rq[g][0] = rq[g][1];
          rn[g]--;
        end
        if (done) begin
          rq[g][rn[g]] = res;
          rn[g]++;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
